// File: rtl/seq_serializer.sv
// Parallel-to-serial converter feeding a downstream sequence detector.
// A word is accepted on a valid/ready handshake and sent one bit per enabled cycle.
module seq_serializer #(
    parameter int   WIDTH      = 8,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             en,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_shifted;
    logic [CW-1:0]    count;
    logic             out_bit;
    logic             load;
    logic             advance;

    // The output end of the register is fixed by the bit order; shifting moves data toward it.
    assign out_bit       = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
    assign shreg_shifted = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                            : {1'b0, shreg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ready is re-opened on the last enabled bit so a waiting word follows with no gap.
    always_comb begin
        state_next = state;
        din_ready  = 1'b0;
        busy       = 1'b0;
        sout_valid = 1'b0;
        frame_done = 1'b0;
        sout       = IDLE_LEVEL;
        load       = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy       = 1'b1;
                sout_valid = en;
                sout       = out_bit;
                if (en) begin
                    if (count == LAST) begin
                        frame_done = 1'b1;
                        din_ready  = 1'b1;
                        if (din_valid) begin
                            load = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            count <= '0;
        end else if (load) begin
            shreg <= din;
            count <= '0;
        end else if (advance) begin
            shreg <= shreg_shifted;
            count <= count + CW'(1);
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: an 8-bit MSB-first and a 5-bit LSB-first instance
// checked every cycle against a word/bit-index model plus a received-word scoreboard.
module tb_seq_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] din_a;
    logic [4:0] din_b;
    logic       dv_a, dv_b, en_a, en_b;
    logic       ready_a, sout_a, sv_a, busy_a, fd_a;
    logic       ready_b, sout_b, sv_b, busy_b, fd_b;

    seq_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .din_valid(dv_a), .din_ready(ready_a),
        .en(en_a), .sout(sout_a), .sout_valid(sv_a), .busy(busy_a), .frame_done(fd_a)
    );

    seq_serializer #(.WIDTH(5), .MSB_FIRST(0), .IDLE_LEVEL(1'b1)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .din_valid(dv_b), .din_ready(ready_b),
        .en(en_b), .sout(sout_b), .sout_valid(sv_b), .busy(busy_b), .frame_done(fd_b)
    );

    int          checks = 0;
    int          fails  = 0;
    int          wid [2] = '{8, 5};
    bit          msb [2] = '{1'b1, 1'b0};
    bit          idl [2] = '{1'b0, 1'b1};
    bit          act [2];
    int          idx [2];
    logic [31:0] word[2];
    logic [31:0] cap [2];
    int          ncap[2];

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s dut%0d observed=%0h expected=%0h t=%0t", tag, d, obs, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input int d, input bit v, input logic [31:0] w, input bit e);
        if (d == 0) begin
            dv_a = v; din_a = w[7:0]; en_a = e;
        end else begin
            dv_b = v; din_b = w[4:0]; en_b = e;
        end
    endtask

    // Expected outputs come from the frame model: which word is in flight and how many bits are gone.
    task automatic check_output();
        for (int d = 0; d < 2; d++) begin
            logic e, last, s_exp, s_obs;
            int   bitpos;
            e      = (d == 0) ? en_a : en_b;
            last   = act[d] && e && (idx[d] == wid[d] - 1);
            bitpos = msb[d] ? (wid[d] - 1 - idx[d]) : idx[d];
            s_exp  = act[d] ? word[d][bitpos] : idl[d];
            s_obs  = (d == 0) ? sout_a : sout_b;
            chk("busy",       d, 32'((d == 0) ? busy_a  : busy_b),  32'(act[d]));
            chk("din_ready",  d, 32'((d == 0) ? ready_a : ready_b), 32'(!act[d] || last));
            chk("sout_valid", d, 32'((d == 0) ? sv_a    : sv_b),    32'(act[d] && e));
            chk("frame_done", d, 32'((d == 0) ? fd_a    : fd_b),    32'(last));
            chk("sout",       d, 32'(s_obs),                        32'(s_exp));
            if (act[d] && e) begin
                if (msb[d]) cap[d] = {cap[d][30:0], s_obs};
                else        cap[d][ncap[d]] = s_obs;
                ncap[d]++;
            end
            if (last) begin
                chk("frame_word", d, cap[d], word[d]);
                cap[d]  = '0;
                ncap[d] = 0;
            end
        end
    endtask

    task automatic update_model();
        for (int d = 0; d < 2; d++) begin
            logic        v, e, rdy;
            logic [31:0] w;
            v   = (d == 0) ? dv_a : dv_b;
            e   = (d == 0) ? en_a : en_b;
            w   = (d == 0) ? 32'(din_a) : 32'(din_b);
            rdy = !act[d] || (e && idx[d] == wid[d] - 1);
            if (rst) begin
                act[d] = 1'b0; idx[d] = 0; cap[d] = '0; ncap[d] = 0;
            end else if (v && rdy) begin
                act[d] = 1'b1; idx[d] = 0; word[d] = w; cap[d] = '0; ncap[d] = 0;
            end else if (act[d] && e) begin
                if (idx[d] == wid[d] - 1) act[d] = 1'b0;
                else                      idx[d]++;
            end
        end
    endtask

    task automatic step();
        #3;
        check_output();
        @(posedge clk);
        #1;
        update_model();
    endtask

    task automatic run_steps(input int d, input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(d, 1'b0, 32'h0, toggle ? ((i % 2) == 0) : 1'b1);
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        apply_stimulus(0, 1'b0, 32'h0, 1'b0);
        apply_stimulus(1, 1'b0, 32'h0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            act[d] = 1'b0; idx[d] = 0; word[d] = '0; cap[d] = '0; ncap[d] = 0;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        $display("[TB] reset and reset-over-handshake");
        step();
        apply_stimulus(0, 1'b1, 32'hAA, 1'b1);
        apply_stimulus(1, 1'b1, 32'h15, 1'b1);
        step();
        rst = 1'b0;
        apply_stimulus(0, 1'b0, 32'h0, 1'b1);
        apply_stimulus(1, 1'b0, 32'h0, 1'b1);
        step();

        $display("[TB] single frame 10010010");
        apply_stimulus(0, 1'b1, 32'h92, 1'b1);
        step();
        run_steps(0, 9, 1'b0);

        $display("[TB] back-to-back A5 then 3C");
        apply_stimulus(0, 1'b1, 32'hA5, 1'b1);
        step();
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(0, 1'b1, 32'h3C, 1'b1);
            step();
        end
        run_steps(0, 9, 1'b0);

        $display("[TB] enable gaps on F0");
        apply_stimulus(0, 1'b1, 32'hF0, 1'b0);
        step();
        run_steps(0, 17, 1'b1);

        $display("[TB] LSB-first 10010");
        apply_stimulus(1, 1'b1, 32'h12, 1'b1);
        step();
        run_steps(1, 6, 1'b0);

        $display("[TB] reset mid-frame then 81");
        apply_stimulus(0, 1'b1, 32'hFF, 1'b1);
        step();
        run_steps(0, 3, 1'b0);
        rst = 1'b1;
        apply_stimulus(0, 1'b0, 32'h0, 1'b1);
        step();
        rst = 1'b0;
        step();
        apply_stimulus(0, 1'b1, 32'h81, 1'b1);
        step();
        run_steps(0, 9, 1'b0);

        $display("[TB] busy ignore");
        apply_stimulus(0, 1'b1, 32'hFF, 1'b1);
        step();
        run_steps(0, 3, 1'b0);
        apply_stimulus(0, 1'b1, 32'h00, 1'b1);
        step();
        run_steps(0, 6, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            apply_stimulus(0, ($urandom_range(0, 2) != 0), $urandom, ($urandom_range(0, 3) != 0));
            apply_stimulus(1, ($urandom_range(0, 2) != 0), $urandom, ($urandom_range(0, 3) != 0));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
